// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel push-button conditioning.
// Each channel has a 2-flop synchronizer, then a debounce FSM that produces a
// registered clean level plus one-cycle press/release pulses. Debounce samples
// are qualified by the clkdiv enable tick clk_en_pi.
// Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STABLE_LO | debounced level is 0, synchronized input agrees
// CHK_HI    | input went high, counting enabled samples towards a press
// STABLE_HI | debounced level is 1 (auto-repeat hold timer runs here)
// CHK_LO    | input went low, counting enabled samples towards a release
module btn_conditioner #(
    parameter int WIDTH          = 4,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int HOLD_TICKS     = 500,
    parameter int RATE_TICKS     = 100
) (
    input  logic             clk_pi,
    input  logic             rst_pi,
    input  logic             clk_en_pi,
    input  logic [WIDTH-1:0] btn_pi,
    output logic [WIDTH-1:0] level_po,
    output logic [WIDTH-1:0] press_po,
    output logic [WIDTH-1:0] release_po
);

    localparam int CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    // Entering a CHK state is the first sample, so the counter reaching
    // DEBOUNCE_TICKS-1 marks the last required sample.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    // Reject parameter values the counters cannot represent.
    if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 65535) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_TICKS out of range 2..65535");
    end
    if (HOLD_TICKS < 1 || RATE_TICKS < 1) begin : g_bad_repeat
        $error("btn_conditioner: HOLD_TICKS and RATE_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;

    state_t          state_q [WIDTH];
    state_t          state_d [WIDTH];
    logic [CW-1:0]   cnt_q   [WIDTH];
    logic [CW-1:0]   cnt_d   [WIDTH];

`ifdef BTN_AUTOREPEAT_EN
    localparam int HMAX = (HOLD_TICKS > RATE_TICKS) ? HOLD_TICKS : RATE_TICKS;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] RATE_LAST = HW'(RATE_TICKS);

    logic [HW-1:0] hold_q [WIDTH];
    logic [HW-1:0] hold_d [WIDTH];
    logic [WIDTH-1:0] rep_q, rep_d;
`endif

    // Synchronizer and debounce next-state / output logic for all channels.
    always_comb begin
        sync1_d   = btn_pi;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_d     = '0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
            // Hold timer only survives while sitting in STABLE_HI, so any
            // entry into STABLE_HI starts from zero.
            hold_d[i]  = '0;
`endif
            case (state_q[i])
                STABLE_LO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = CHK_HI;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_HI: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                    end else if (clk_en_pi) begin
                        if (cnt_q[i] + CW'(1) == CNT_LAST) begin
                            state_d[i] = STABLE_HI;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = CHK_LO;
                        cnt_d[i]   = '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else begin
                        hold_d[i] = hold_q[i];
                        rep_d[i]  = rep_q[i];
                        if (clk_en_pi) begin
                            if (hold_q[i] + HW'(1) == (rep_q[i] ? RATE_LAST : HOLD_LAST)) begin
                                hold_d[i]  = '0;
                                rep_d[i]   = 1'b1;
                                press_d[i] = 1'b1;
                            end else begin
                                hold_d[i] = hold_q[i] + HW'(1);
                            end
                        end
                    end
`endif
                end
                CHK_LO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                    end else if (clk_en_pi) begin
                        if (cnt_q[i] + CW'(1) == CNT_LAST) begin
                            state_d[i]   = STABLE_LO;
                            cnt_d[i]     = '0;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = STABLE_LO;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Synchronizer and registered output flops.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Per-channel FSM state and debounce counters.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat hold timers and first-repeat-done flags.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            for (int i = 0; i < WIDTH; i++) begin
                hold_q[i] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                hold_q[i] <= hold_d[i];
            end
            rep_q <= rep_d;
        end
    end
`endif

    assign level_po   = level_q;
    assign press_po   = press_q;
    assign release_po = release_q;

endmodule
